// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared types and helpers for the multi-port banked ARM
//               register file (processor modes, special-register indices,
//               physical storage sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    // Processor modes; the unused encoding 2'b11 is handled as USR by the map
    typedef enum logic [1:0] {
        MODE_USR = 2'b00,
        MODE_IRQ = 2'b01,
        MODE_SVC = 2'b10
    } mode_t;

    // Offsets of the special registers counted down from NUM_REGS
    localparam int c_PC_OFS = 1;
    localparam int c_LR_OFS = 2;
    localparam int c_SP_OFS = 3;

    // Logical index of a special register (PC/LR/SP) for a given file size
    function automatic int special_idx(input int num_regs, input int ofs);
        return num_regs - ofs;
    endfunction

    // Physical storage: NUM_REGS-3 shared entries plus three SP/LR pairs
    function automatic int phys_entries(input int num_regs);
        return num_regs + 3;
    endfunction

    // Width of a physical storage index
    function automatic int phys_width(input int num_regs);
        return $clog2(num_regs + 3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_bank_map.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_bank_map
// Description : Combinational logical-to-physical register map. SP and LR
//               are steered to the copy owned by the current mode; the PC
//               index has no storage and is flagged instead.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_bank_map
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = 16,
    localparam int ADDR_W  = $clog2(NUM_REGS),
    localparam int PHYS_W  = phys_width(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        mode,
    output logic [PHYS_W-1:0] phys,
    output logic              is_pc
);

    localparam int c_PC = special_idx(NUM_REGS, c_PC_OFS);
    localparam int c_LR = special_idx(NUM_REGS, c_LR_OFS);
    localparam int c_SP = special_idx(NUM_REGS, c_SP_OFS);

    // Bank layout above the shared entries: SP_USR, LR_USR, SP_IRQ, LR_IRQ,
    // SP_SVC, LR_SVC. So bank b places SP at c_SP+2b and LR at c_LR+2b.
    logic [1:0] w_bank;

    // Select the bank for the current mode; reserved mode falls back to USR
    always_comb begin
        w_bank = 2'd0;
        case (mode)
            MODE_IRQ: w_bank = 2'd1;
            MODE_SVC: w_bank = 2'd2;
            default:  w_bank = 2'd0;
        endcase
    end

    // Map the logical index to its physical slot
    always_comb begin
        phys  = PHYS_W'(addr);
        is_pc = (addr == ADDR_W'(c_PC));
        if (addr == ADDR_W'(c_SP)) begin
            phys = PHYS_W'(c_SP + 2 * int'(w_bank));
        end else if (addr == ADDR_W'(c_LR)) begin
            phys = PHYS_W'(c_LR + 2 * int'(w_bank));
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_mp
// Description : Multi-port ARM register file: NUM_RD combinational reads,
//               two synchronous writes (port 0 wins), banked SP/LR, virtual
//               PC (reads return pc_plus8, writes become a branch request),
//               optional same-cycle write forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [DATA_W-1:0]        pc_plus8,
    output logic                     pc_write,
    output logic [DATA_W-1:0]        pc_wdata,
    output logic                     wr_collision
);

    localparam int PHYS_N = phys_entries(NUM_REGS);
    localparam int PHYS_W = phys_width(NUM_REGS);

    logic [DATA_W-1:0] r_regs [PHYS_N];
    logic              r_pc_write;
    logic [DATA_W-1:0] r_pc_wdata;
    logic              r_wr_collision;

    logic [PHYS_W-1:0] w_phys0;
    logic [PHYS_W-1:0] w_phys1;
    logic              w_is_pc0;
    logic              w_is_pc1;
    logic              w_collide;
    logic              w_commit0;
    logic              w_commit1;
    logic              w_pc_hit0;
    logic              w_pc_hit1;

    reg_file_bank_map #(.NUM_REGS(NUM_REGS)) u_map_w0 (
        .addr  (wa0),
        .mode  (mode),
        .phys  (w_phys0),
        .is_pc (w_is_pc0)
    );

    reg_file_bank_map #(.NUM_REGS(NUM_REGS)) u_map_w1 (
        .addr  (wa1),
        .mode  (mode),
        .phys  (w_phys1),
        .is_pc (w_is_pc1)
    );

    // Same logical address on both ports: port 1 is dropped. Logical equality
    // is enough since both ports map through the same mode.
    assign w_collide = we0 && we1 && (wa0 == wa1);
    assign w_pc_hit0 = we0 && w_is_pc0;
    assign w_pc_hit1 = we1 && w_is_pc1;
    assign w_commit0 = we0 && !w_is_pc0;
    assign w_commit1 = we1 && !w_is_pc1 && !w_collide;

    // Commit array writes and register the PC-redirect / collision pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHYS_N; i++) begin
                r_regs[i] <= '0;
            end
            r_pc_write     <= 1'b0;
            r_pc_wdata     <= '0;
            r_wr_collision <= 1'b0;
        end else begin
            if (w_commit1) begin
                r_regs[w_phys1] <= wd1;
            end
            if (w_commit0) begin
                r_regs[w_phys0] <= wd0;
            end
            r_pc_write     <= w_pc_hit0 || w_pc_hit1;
            r_wr_collision <= w_collide;
            if (w_pc_hit0) begin
                r_pc_wdata <= wd0;
            end else if (w_pc_hit1) begin
                r_pc_wdata <= wd1;
            end
        end
    end

    assign pc_write     = r_pc_write;
    assign pc_wdata     = r_pc_wdata;
    assign wr_collision = r_wr_collision;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [PHYS_W-1:0] w_phys;
        logic              w_is_pc;
        logic [DATA_W-1:0] w_stored;
        logic [DATA_W-1:0] w_out;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        reg_file_bank_map #(.NUM_REGS(NUM_REGS)) u_map_rd (
            .addr  (w_addr),
            .mode  (mode),
            .phys  (w_phys),
            .is_pc (w_is_pc)
        );

        assign w_stored = w_is_pc ? pc_plus8 : r_regs[w_phys];

        if (BYPASS != 0) begin : g_bypass
            // Forward a same-cycle write (port 0 first); PC is never forwarded
            // and writes discarded by reset are not forwarded either
            always_comb begin
                w_out = w_stored;
                if (!reset && !w_is_pc) begin
                    if (we0 && (wa0 == w_addr)) begin
                        w_out = wd0;
                    end else if (we1 && (wa1 == w_addr)) begin
                        w_out = wd1;
                    end
                end
            end
        end else begin : g_no_bypass
            assign w_out = w_stored;
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_out;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Self-checking bench for reg_file_mp: directed scenarios plus
//               randomized traffic against a logical-register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int NUM_RD   = 3;
    localparam int BYPASS   = 1;
    localparam int ADDR_W   = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [1:0]               mode;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     we0, we1;
    logic [ADDR_W-1:0]        wa0, wa1;
    logic [DATA_W-1:0]        wd0, wd1;
    logic [DATA_W-1:0]        pc_plus8;
    logic                     pc_write;
    logic [DATA_W-1:0]        pc_wdata;
    logic                     wr_collision;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .we0          (we0),
        .wa0          (wa0),
        .wd0          (wd0),
        .we1          (we1),
        .wa1          (wa1),
        .wd1          (wd1),
        .pc_plus8     (pc_plus8),
        .pc_write     (pc_write),
        .pc_wdata     (pc_wdata),
        .wr_collision (wr_collision)
    );

    // Reference model: architectural view, one value per logical register
    // per bank (bank 0 USR, 1 IRQ, 2 SVC).
    logic [DATA_W-1:0] m_shared [13];
    logic [DATA_W-1:0] m_sp [3];
    logic [DATA_W-1:0] m_lr [3];

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int bank_of(input logic [1:0] m);
        if (m == 2'b01) return 1;
        if (m == 2'b10) return 2;
        return 0;
    endfunction

    function automatic logic [DATA_W-1:0] m_stored(input logic [ADDR_W-1:0] a, input logic [1:0] m);
        if (a == 4'd15) return pc_plus8;
        if (a == 4'd14) return m_lr[bank_of(m)];
        if (a == 4'd13) return m_sp[bank_of(m)];
        return m_shared[a];
    endfunction

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (BYPASS != 0 && a != 4'd15 && !reset) begin
            if (we0 && wa0 == a) return wd0;
            if (we1 && wa1 == a) return wd1;
        end
        return m_stored(a, mode);
    endfunction

    task automatic m_store(input logic [ADDR_W-1:0] a, input logic [1:0] m, input logic [DATA_W-1:0] d);
        if (a == 4'd15) return;
        if (a == 4'd14) m_lr[bank_of(m)] = d;
        else if (a == 4'd13) m_sp[bank_of(m)] = d;
        else m_shared[a] = d;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 13; i++) m_shared[i] = '0;
        for (int i = 0; i < 3; i++) begin
            m_sp[i] = '0;
            m_lr[i] = '0;
        end
    endtask

    task automatic check_reads(input string tag);
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            a = rd_addr[k*ADDR_W +: ADDR_W];
            check($sformatf("%s port%0d addr%0d mode%0d", tag, k, a, mode),
                  rd_data[k*DATA_W +: DATA_W], exp_read(a));
        end
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; we1 = 1'b0;
        wa0 = '0;   wa1 = '0;
        wd0 = '0;   wd1 = '0;
    endtask

    // Read one address on port 0 with writes idle (called at/after negedge)
    task automatic read0(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        rd_addr[ADDR_W-1:0] = a;
        #1;
        d = rd_data[DATA_W-1:0];
    endtask

    // One clock cycle starting at a negedge with inputs already applied:
    // check reads before the edge, then pulses and model after it.
    task automatic tick(input bit chk_reads);
        logic exp_col, exp_pcw;
        logic [DATA_W-1:0] exp_pcd;
        #1;
        if (chk_reads && !reset) check_reads("rd");
        exp_col = !reset && we0 && we1 && (wa0 == wa1);
        exp_pcw = !reset && ((we0 && wa0 == 4'd15) || (we1 && wa1 == 4'd15));
        exp_pcd = (we0 && wa0 == 4'd15) ? wd0 : wd1;
        @(posedge clk);
        if (reset) begin
            m_clear();
        end else begin
            if (we1) m_store(wa1, mode, wd1);
            if (we0) m_store(wa0, mode, wd0);
        end
        #1;
        check("wr_collision", {31'b0, wr_collision}, {31'b0, exp_col});
        check("pc_write", {31'b0, pc_write}, {31'b0, exp_pcw});
        if (reset) check("pc_wdata reset", pc_wdata, '0);
        else if (exp_pcw) check("pc_wdata", pc_wdata, exp_pcd);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        reset = 1'b1;
        mode = 2'b00;
        rd_addr = '0;
        pc_plus8 = 32'h108;
        idle_inputs();
        m_clear();
        @(negedge clk);
        tick(0);
        tick(0);
        reset = 1'b0;

        // Reset state across all addresses
        for (int a = 0; a < 16; a++) begin
            read0(ADDR_W'(a), d);
            check($sformatf("reset R%0d", a), d, (a == 15) ? 32'h108 : 32'h0);
        end
        check("reset pc_write", {31'b0, pc_write}, 32'h0);
        check("reset wr_collision", {31'b0, wr_collision}, 32'h0);

        // Two independent writes in one cycle, forwarded on the same cycle
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hDEADBEEF;
        we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h12345678;
        rd_addr = {4'd0, 4'd5, 4'd3};
        #1;
        check("bypass R3", rd_data[31:0], 32'hDEADBEEF);
        check("bypass R5", rd_data[63:32], 32'h12345678);
        tick(1);
        idle_inputs();
        #1;
        check("R3 after write", rd_data[31:0], 32'hDEADBEEF);
        check("R5 after write", rd_data[63:32], 32'h12345678);

        // Banked SP
        mode = 2'b00; we0 = 1'b1; wa0 = 4'd13; wd0 = 32'h1000;
        tick(1);
        mode = 2'b10; wd0 = 32'h2000;
        tick(1);
        idle_inputs();
        mode = 2'b10; read0(4'd13, d); check("SP SVC", d, 32'h2000);
        mode = 2'b00; read0(4'd13, d); check("SP USR", d, 32'h1000);
        mode = 2'b01; read0(4'd13, d); check("SP IRQ", d, 32'h0);
        mode = 2'b11; read0(4'd13, d); check("SP mode3", d, 32'h1000);
        mode = 2'b00;

        // Collision on R7
        we0 = 1'b1; wa0 = 4'd7; wd0 = 32'hA;
        we1 = 1'b1; wa1 = 4'd7; wd1 = 32'hB;
        tick(1);
        idle_inputs();
        check("collision pulse", {31'b0, wr_collision}, 32'h1);
        read0(4'd7, d); check("R7 collision", d, 32'hA);
        tick(1);
        check("collision cleared", {31'b0, wr_collision}, 32'h0);

        // PC write via port 1
        we1 = 1'b1; wa1 = 4'd15; wd1 = 32'h8000;
        tick(1);
        idle_inputs();
        check("pc_write pulse", {31'b0, pc_write}, 32'h1);
        check("pc_wdata value", pc_wdata, 32'h8000);
        read0(4'd15, d); check("R15 is pc_plus8", d, 32'h108);
        tick(1);
        check("pc_write cleared", {31'b0, pc_write}, 32'h0);
        for (int a = 0; a < 16; a += 3) begin
            rd_addr = {ADDR_W'(a + 2), ADDR_W'(a + 1), ADDR_W'(a)};
            #1;
            check_reads("after pc write");
        end

        // Reset discards a simultaneous write
        we0 = 1'b1; wa0 = 4'd2; wd0 = 32'h55; reset = 1'b1;
        tick(0);
        reset = 1'b0;
        idle_inputs();
        read0(4'd2, d); check("R2 after reset", d, 32'h0);
        check("pc_write after reset", {31'b0, pc_write}, 32'h0);
        check("collision after reset", {31'b0, wr_collision}, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 59) == 0);
            mode     = 2'($urandom_range(0, 3));
            pc_plus8 = $urandom;
            we0      = 1'($urandom_range(0, 1));
            we1      = 1'($urandom_range(0, 1));
            wa0      = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            wa1      = ($urandom_range(0, 5) == 0) ? wa0 : 4'($urandom_range(10, 15));
            wd0      = $urandom;
            wd1      = $urandom;
            for (int k = 0; k < NUM_RD; k++) begin
                rd_addr[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 2) == 0) ? wa0 : 4'($urandom_range(0, 15));
            end
            tick(1);
        end

        // Final sweep over every mode with writes idle
        reset = 1'b0;
        idle_inputs();
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            for (int a = 0; a < 16; a += 3) begin
                rd_addr = {ADDR_W'(a + 2), ADDR_W'(a + 1), ADDR_W'(a)};
                #1;
                check_reads("sweep");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port ARM register file, the next generation of the core's single-write register file. It provides NUM_RD combinational read ports and two synchronous write ports (ALU result and load/base writeback). R13/R14 are banked per processor mode, and write-through bypass is optional. The PC index is virtual: reads return pc_plus8, and writes become a registered branch request to the fetch stage.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 16, logical registers; power of two, ≥ 4; ADDR_W = log2(NUM_REGS)
- NUM_RD, 3, number of read ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mode  in  2  processor mode: 00 USR, 01 IRQ, 10 SVC, 11 reserved (treated as USR)
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing
- we0 / wa0 / wd0  in  1 / ADDR_W / DATA_W  write port 0 (ALU result); highest priority
- we1 / wa1 / wd1  in  1 / ADDR_W / DATA_W  write port 1 (load / base writeback)
- pc_plus8  in  DATA_W  current PC + 8, returned for reads of PC_IDX
- pc_write  out  1  registered one-cycle pulse: a write targeted PC_IDX
- pc_wdata  out  DATA_W  registered data accompanying pc_write
- wr_collision  out  1  registered one-cycle pulse: both ports wrote the same logical address

## Operation
- Fixed indices: PC_IDX = NUM_REGS-1, LR_IDX = NUM_REGS-2, SP_IDX = NUM_REGS-3.
- Physical storage is NUM_REGS-1+4 entries: NUM_REGS-3 shared registers, plus USR/IRQ/SVC copies of SP and LR. No storage exists for PC.
- Logical-to-physical mapping uses the current `mode` for both reads and writes in the same cycle.
- Read of PC_IDX returns pc_plus8 (never bypassed). Any other read returns the mapped entry. With BYPASS=1, a matching write in the same cycle is returned instead: port 0 data over port 1 data over stored data.
- A write to PC_IDX does not touch the array. It sets pc_write=1 and pc_wdata=write data on the next edge. If both ports target PC, port 0 data is used.
- If we0 and we1 are both high with wa0==wa1: only port 0 is committed, and wr_collision=1 next cycle. This applies to the PC index too.
- Writes to different addresses commit in the same edge.
- A write to SP/LR in a given mode changes only that mode's copy. The other banks are unaffected.
- Reset: every physical entry = 0, pc_write=0, pc_wdata=0, wr_collision=0. Write enables are ignored during a reset cycle. Reset asserted mid-operation discards any write presented that cycle.

## Timing
- Read path is fully combinational: address/mode/pc_plus8 (and, with BYPASS, write inputs) to rd_data within the same cycle.
- Write latency is one edge. With BYPASS=0, a written value is visible on reads the cycle after we.
- pc_write and wr_collision are high for exactly one cycle per causing event. Events in consecutive cycles produce back-to-back pulses.
- A mode change takes effect on reads and writes immediately, in the same cycle.

## Structure
- Package reg_file_pkg holds:
  - mode_t enum (MODE_USR, MODE_IRQ, MODE_SVC);
  - a function giving PC/LR/SP index offsets from NUM_REGS;
  - a physical-index width helper.
- Sub-module reg_file_bank_map is a combinational map from (logical addr, mode) to (physical index, is_pc). It is instantiated once per read port and once per write port.
- Top level holds the storage array, the write/collision/pc_write registers, and the bypass muxes (generate-gated on BYPASS).

## Test plan
- Reset, then read all 16 addresses in USR with pc_plus8=0x108 → R0..R14 read 0, R15 reads 0x108; pc_write=0 and wr_collision=0.
- USR: we0 wa0=3 wd0=0xDEADBEEF; we1 wa1=5 wd1=0x12345678, same cycle → next cycle R3=0xDEADBEEF and R5=0x12345678. With BYPASS=1, both values also appear on the same cycle's reads.
- Write SP=0x1000 in USR, switch mode to SVC, write SP=0x2000 → SVC reads SP=0x2000, USR reads SP=0x1000, IRQ reads SP=0. Mode 11 reads 0x1000.
- we0 and we1 both to R7, wd0=0xA, wd1=0xB → R7=0xA, wr_collision=1 for one cycle, then 0.
- we1 wa1=15 wd1=0x8000 → next cycle pc_write=1 and pc_wdata=0x8000 for one cycle; R15 reads still return pc_plus8; no array entry changes.
- Reset asserted in the same cycle as we0 wa0=2 wd0=0x55 → R2 reads 0 after the edge; all pulse outputs are 0.
